// File: rtl/se_fc_feeder.sv
// se_fc_feeder: issue sequencer feeding the 32-lane adder tree for the SE-block FC layers.
//   Runs one layer (FC1 or FC2) per accepted start. For each neuron it reads activation and
//   weight vectors beat by beat and emits one packed vector of fixed-point products per cycle.
//   clk, rst (async, active-low)      clock and reset
//   start, layer_sel                  run request and layer choice (0 = FC1, 1 = FC2)
//   act_addr, w_addr, rd_en           read port to activation and weight memories (1-cycle latency)
//   act_rdata, w_rdata                packed signed operands, lane 0 at LSBs
//   input_numbers, start_adder        product beat and its valid
//   fully_1, fully_2                  layer flags for the current beat
//   fc1_max_loop, fc2_max_loop        beats per neuron for each layer (constants)
//   busy, done                        run in progress / one-cycle completion pulse
//   Macro SE_FC_ROUND_EN: round-half-up before the fractional shift; otherwise truncate.
module se_fc_feeder #(
    parameter int bitsize   = 14,
    parameter int FRAC_BITS = 7,
    parameter int NUM_LANES = 32,
    parameter int FC1_IN    = 576,
    parameter int FC1_OUT   = 144,
    parameter int FC2_IN    = 144,
    parameter int FC2_OUT   = 576,
    parameter int A_ADDR_W  = 5,
    parameter int W_ADDR_W  = 12
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic                                         layer_sel,
    output logic [A_ADDR_W-1:0]                          act_addr,
    input  logic [NUM_LANES*bitsize-1:0]                 act_rdata,
    output logic [W_ADDR_W-1:0]                          w_addr,
    input  logic [NUM_LANES*bitsize-1:0]                 w_rdata,
    output logic                                         rd_en,
    output logic [NUM_LANES*(2*bitsize-FRAC_BITS)-1:0]   input_numbers,
    output logic                                         start_adder,
    output logic                                         fully_1,
    output logic                                         fully_2,
    output logic [4:0]                                   fc1_max_loop,
    output logic [2:0]                                   fc2_max_loop,
    output logic                                         busy,
    output logic                                         done
);
    localparam int PW        = 2*bitsize;
    localparam int OW        = 2*bitsize - FRAC_BITS;
    localparam int FC1_LOOPS = (FC1_IN + NUM_LANES - 1) / NUM_LANES;
    localparam int FC2_LOOPS = (FC2_IN + NUM_LANES - 1) / NUM_LANES;
    localparam int MAX_OUT   = (FC1_OUT > FC2_OUT) ? FC1_OUT : FC2_OUT;
    localparam int NW        = $clog2(MAX_OUT + 1);
    localparam int LW        = $clog2(NUM_LANES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                      state, state_n;
    logic [A_ADDR_W-1:0]         beat_cnt, beat_n, loops;
    logic [NW-1:0]               neuron_cnt, neuron_n, out_n;
    logic                        layer, layer_n, drain, drain_n;
    logic [15:0]                 rem;
    logic [LW-1:0]               lanes_c, lanes_a, lanes_b;
    logic                        layer_a, layer_b, valid_b;
    logic [W_ADDR_W-1:0]         waddr_c;
    logic [NUM_LANES*OW-1:0]     prod_c;

    assign fc1_max_loop = 5'(FC1_LOOPS);
    assign fc2_max_loop = 3'(FC2_LOOPS);

    assign loops   = layer ? A_ADDR_W'(FC2_LOOPS) : A_ADDR_W'(FC1_LOOPS);
    assign out_n   = layer ? NW'(FC2_OUT) : NW'(FC1_OUT);
    assign waddr_c = W_ADDR_W'(neuron_cnt) * W_ADDR_W'(loops) + W_ADDR_W'(beat_cnt);
    // Elements still left in the input vector at this beat; lanes at or beyond it are padding.
    assign rem     = (layer ? 16'(FC2_IN) : 16'(FC1_IN)) - 16'(beat_cnt) * 16'(NUM_LANES);
    assign lanes_c = (rem >= 16'(NUM_LANES)) ? LW'(NUM_LANES) : LW'(rem);

    always_comb begin
        state_n  = state;
        beat_n   = beat_cnt;
        neuron_n = neuron_cnt;
        layer_n  = layer;
        drain_n  = drain;
        case (state)
            IDLE: if (start) begin
                state_n  = ISSUE;
                layer_n  = layer_sel;
                beat_n   = '0;
                neuron_n = '0;
            end
            ISSUE: if (beat_cnt == loops - 1'b1) begin
                beat_n   = '0;
                neuron_n = neuron_cnt + 1'b1;
                if (neuron_cnt == out_n - 1'b1) begin
                    state_n = DRAIN;
                    drain_n = 1'b0;
                end
            end else begin
                beat_n = beat_cnt + 1'b1;
            end
            // Two cycles cover the memory read and the product register.
            DRAIN: begin
                drain_n = 1'b1;
                if (drain) state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic signed [PW-1:0] p, pr;
        assign p = $signed(act_rdata[g*bitsize +: bitsize]) * $signed(w_rdata[g*bitsize +: bitsize]);
`ifdef SE_FC_ROUND_EN
        assign pr = p + PW'(1 << (FRAC_BITS - 1));
`else
        assign pr = p;
`endif
        assign prod_c[g*OW +: OW] = (LW'(g) < lanes_b) ? OW'(pr >>> FRAC_BITS) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            neuron_cnt    <= '0;
            layer         <= 1'b0;
            drain         <= 1'b0;
            rd_en         <= 1'b0;
            act_addr      <= '0;
            w_addr        <= '0;
            lanes_a       <= '0;
            layer_a       <= 1'b0;
            valid_b       <= 1'b0;
            lanes_b       <= '0;
            layer_b       <= 1'b0;
            start_adder   <= 1'b0;
            input_numbers <= '0;
            fully_1       <= 1'b0;
            fully_2       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_n;
            beat_cnt      <= beat_n;
            neuron_cnt    <= neuron_n;
            layer         <= layer_n;
            drain         <= drain_n;
            rd_en         <= state == ISSUE;
            act_addr      <= (state == ISSUE) ? beat_cnt : '0;
            w_addr        <= (state == ISSUE) ? waddr_c : '0;
            lanes_a       <= lanes_c;
            layer_a       <= layer;
            valid_b       <= rd_en;
            lanes_b       <= lanes_a;
            layer_b       <= layer_a;
            start_adder   <= valid_b;
            input_numbers <= valid_b ? prod_c : '0;
            fully_1       <= valid_b & ~layer_b;
            fully_2       <= valid_b & layer_b;
            busy          <= state_n != IDLE;
            done          <= state == DONE;
        end
    end
endmodule

// File: tb/tb_se_fc_feeder.sv
// tb_se_fc_feeder: self-checking bench for se_fc_feeder against a lane-level arithmetic model.
module tb_se_fc_feeder;
    localparam int W  = 14;
    localparam int OW = 21;
    localparam int L  = 32;
    localparam int VW = L*OW;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           layer_sel = 1'b0;
    logic [4:0]     act_addr;
    logic [11:0]    w_addr;
    logic [L*W-1:0] act_rdata = '0;
    logic [L*W-1:0] w_rdata = '0;
    logic           rd_en, start_adder, fully_1, fully_2, busy, done;
    logic [VW-1:0]  input_numbers;
    logic [4:0]     fc1_max_loop;
    logic [2:0]     fc2_max_loop;

    logic [L*W-1:0] act_mem [0:31];
    logic [L*W-1:0] w_mem [0:4095];

    int passed = 0, total = 0, cyc = 0;
    int beats = 0, rds = 0, done_cnt = 0, first_cyc = 0, last_cyc = 0, done_cyc = 0;
    bit mon_layer = 1'b0, h1 = 1'b0, h2 = 1'b0;
    longint sum0 = 0;
    logic [VW-1:0] first_vec = '0, vec4 = '0, ev;

    se_fc_feeder dut (
        .clk(clk), .rst(rst), .start(start), .layer_sel(layer_sel),
        .act_addr(act_addr), .act_rdata(act_rdata), .w_addr(w_addr), .w_rdata(w_rdata),
        .rd_en(rd_en), .input_numbers(input_numbers), .start_adder(start_adder),
        .fully_1(fully_1), .fully_2(fully_2), .fc1_max_loop(fc1_max_loop),
        .fc2_max_loop(fc2_max_loop), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (rd_en) begin
        act_rdata <= act_mem[act_addr];
        w_rdata   <= w_mem[w_addr];
    end

    function automatic int lp(bit ly);
        return ly ? 5 : 18;
    endfunction

    function automatic int nbeats(bit ly);
        return ly ? 5*576 : 18*144;
    endfunction

    // Beat k of a layer: neuron k/loops, chunk k%loops; each lane is floor(a*w/128), padded past IN.
    function automatic logic [VW-1:0] model(bit ly, int k);
        logic [VW-1:0] r = '0;
        logic signed [W-1:0] av, wv;
        int n = k / lp(ly), b = k % lp(ly), inn = ly ? 144 : 576;
        int p, q;
        for (int l = 0; l < L; l++) begin
            if (b*L + l < inn) begin
                av = act_mem[b][l*W +: W];
                wv = w_mem[n*lp(ly) + b][l*W +: W];
                p = int'(av) * int'(wv);
`ifdef SE_FC_ROUND_EN
                p = p + 64;
`endif
                q = p / 128;
                if (p < 0 && p % 128 != 0) q = q - 1;
                r[l*OW +: OW] = q[OW-1:0];
            end
        end
        return r;
    endfunction

    task automatic check(string tag, longint obs, longint exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic fill(int mode);
        for (int r = 0; r < 32; r++)
            for (int l = 0; l < L; l++)
                act_mem[r][l*W +: W] = (mode == 0) ? 14'd128 : (mode == 1) ? 14'h3FFD : W'($urandom);
        for (int r = 0; r < 4096; r++)
            for (int l = 0; l < L; l++)
                w_mem[r][l*W +: W] = (mode == 0) ? 14'd128 : (mode == 1) ? 14'd64 : W'($urandom);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            h1 = 1'b0;
            h2 = 1'b0;
        end else begin
            if (start && !busy) begin
                mon_layer = layer_sel;
                beats = 0;
                rds = 0;
                done_cnt = 0;
                sum0 = 0;
            end
            check("lag", longint'(start_adder), longint'(h2));
            h2 = h1;
            h1 = rd_en;
            if (rd_en) begin
                check("act_addr", longint'(act_addr), rds % lp(mon_layer));
                check("w_addr", longint'(w_addr), (rds / lp(mon_layer)) * lp(mon_layer) + rds % lp(mon_layer));
                rds++;
            end
            check("fully_1", longint'(fully_1), longint'(start_adder && !mon_layer));
            check("fully_2", longint'(fully_2), longint'(start_adder && mon_layer));
            if (start_adder) begin
                ev = model(mon_layer, beats);
                total++;
                assert (input_numbers === ev) passed++;
                else $error("FAIL beat %0d: observed %h expected %h", beats, input_numbers, ev);
                if (beats == 0) begin
                    first_vec = input_numbers;
                    first_cyc = cyc;
                end
                if (beats == 4) vec4 = input_numbers;
                if (beats < lp(mon_layer))
                    for (int l = 0; l < L; l++) sum0 += longint'($signed(input_numbers[l*OW +: OW]));
                last_cyc = cyc;
                beats++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic run(bit ly, bit poke);
        int t = 0;
        @(posedge clk); #1 start = 1'b1; layer_sel = ly;
        @(posedge clk); #1 start = 1'b0; layer_sel = 1'b0;
        check("busy_running", longint'(busy), 1);
        while (done !== 1'b1 && t < 4000) begin
            @(negedge clk);
            t++;
            if (poke && t == 300) begin
                @(posedge clk); #1 start = 1'b1; layer_sel = 1'b1;
                @(posedge clk); #1 start = 1'b0; layer_sel = 1'b0;
            end
        end
        check("done_timeout", longint'(t < 4000), 1);
        @(negedge clk);
        check("beat_count", beats, nbeats(ly));
        check("rd_count", rds, nbeats(ly));
        check("contiguous", last_cyc - first_cyc, nbeats(ly) - 1);
        check("done_after_last", done_cyc, last_cyc + 1);
        check("done_pulses", done_cnt, 1);
        check("busy_idle", longint'(busy), 0);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_rd_en"}, longint'(rd_en), 0);
        check({tag, "_start_adder"}, longint'(start_adder), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_act_addr"}, longint'(act_addr), 0);
        check({tag, "_w_addr"}, longint'(w_addr), 0);
        check({tag, "_fully"}, longint'({fully_1, fully_2}), 0);
        check({tag, "_input_numbers"}, longint'(input_numbers === '0), 1);
    endtask

    initial begin
        int t, b;
        fill(0);
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        check("fc1_max_loop", longint'(fc1_max_loop), 18);
        check("fc2_max_loop", longint'(fc2_max_loop), 5);
        rst = 1'b1;

        run(1'b0, 1'b0);
        check("fc1_ones_lane0", longint'($signed(first_vec[OW-1:0])), 128);
        check("fc1_neuron0_sum", sum0, 73728);

        run(1'b1, 1'b0);
        check("fc2_ones_sum", sum0, 18432);
        check("fc2_pad_lanes", longint'(vec4[VW-1:16*OW] === '0), 1);
        check("fc2_beat4_lane15", longint'($signed(vec4[15*OW +: OW])), 128);

        fill(1);
        run(1'b1, 1'b0);
`ifdef SE_FC_ROUND_EN
        check("sign_round", longint'($signed(first_vec[OW-1:0])), -1);
`else
        check("sign_trunc", longint'($signed(first_vec[OW-1:0])), -2);
`endif

        fill(2);
        run(1'b0, 1'b1);

        @(posedge clk); #1 start = 1'b1; layer_sel = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        t = 0;
        while (beats < 100 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("reach_beat100", longint'(t < 500), 1);
        rst = 1'b0;
        #1;
        check_zero("midreset");
        b = beats;
        @(posedge clk); #1 rst = 1'b1;
        repeat (10) @(negedge clk);
        check("no_beats_after_reset", beats, b);
        check("idle_after_reset", longint'(busy), 0);
        run(1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/se_fc_feeder.md
Name: se_fc_feeder

Overview:
Issue sequencer for the SE-block fully-connected layers. It drives the 32-lane pipelined adder tree. For each output neuron it fetches activation and weight vectors, forms 32 fixed-point products, zero-pads lanes past the input length, and streams one packed product vector per cycle with the layer flags and loop counts. It has no backpressure, because the adder tree accepts one beat per cycle unconditionally.

Parameters:
bitsize, 14, operand width (signed Q format)
FRAC_BITS, 7, fractional bits removed from each product
NUM_LANES, 32, lanes per beat
FC1_IN, 576, FC1 input length
FC1_OUT, 144, FC1 neuron count
FC2_IN, 144, FC2 input length
FC2_OUT, 576, FC2 neuron count
A_ADDR_W, 5, activation address width
W_ADDR_W, 12, weight address width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle request to run a layer; ignored while busy
layer_sel  in  1  0 = FC1, 1 = FC2; sampled with start
act_addr  out  A_ADDR_W  activation vector address (beat index)
act_rdata  in  NUM_LANES*bitsize  32 packed signed activations, valid 1 cycle after address
w_addr  out  W_ADDR_W  weight vector address
w_rdata  in  NUM_LANES*bitsize  32 packed signed weights, valid 1 cycle after address
rd_en  out  1  read strobe for both memories
input_numbers  out  NUM_LANES*(2*bitsize-FRAC_BITS)  packed products, lane 0 at LSBs
start_adder  out  1  beat valid
fully_1  out  1  beat belongs to FC1
fully_2  out  1  beat belongs to FC2
fc1_max_loop  out  5  constant ceil(FC1_IN/NUM_LANES) = 18
fc2_max_loop  out  3  constant ceil(FC2_IN/NUM_LANES) = 5
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the last beat has been issued

Behaviour:
- Reset values:
  - All registered outputs are 0: addresses, rd_en, input_numbers, start_adder, fully_1, fully_2, busy, done.
  - FSM is in IDLE.
  - fc1_max_loop and fc2_max_loop are constants.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: on start, latch layer_sel, clear beat_cnt and neuron_cnt, go to ISSUE.
  - ISSUE: each cycle, rd_en = 1, act_addr = beat_cnt, w_addr = neuron_cnt*loops + beat_cnt.
    - beat_cnt wraps at loops-1. On wrap, neuron_cnt increments.
    - After the address with neuron_cnt = OUT-1 and beat_cnt = loops-1, go to DRAIN.
    - loops and OUT come from the latched layer.
  - DRAIN: wait 2 cycles for the read and multiply pipeline to empty, then go to DONE.
  - DONE: pulse done for 1 cycle, drop busy, return to IDLE.
- Pipeline:
  - Stage A: address plus a valid/lane-mask tag.
  - Stage B: memory data returns.
  - Stage C: registered products.
  - start_adder rises exactly 2 cycles after the corresponding rd_en.
  - Beats are contiguous: FC1 is 2592 back-to-back beats, FC2 is 2880.
- Lane arithmetic:
  - p = signed(a)*signed(w), 2*bitsize bits.
  - Output lane = p >>> FRAC_BITS (arithmetic shift), keeping the low 2*bitsize-FRAC_BITS bits. The shifted value always fits, so there is no saturation.
- Padding: a lane whose element index beat*NUM_LANES + lane is >= IN outputs 0. Example: FC2 beat 4, lanes 16..31 are 0.
- Layer flags:
  - fully_1 and fully_2 are valid on every start_adder beat; exactly one is high.
  - Both are 0 whenever start_adder = 0.
- start while busy (ISSUE, DRAIN or DONE) is ignored; no queueing.
- Reset mid-operation: all state clears immediately, and no further start_adder beats are issued.

Optional Feature:
Macro SE_FC_ROUND_EN.
- Defined: round-half-up. Add 1 << (FRAC_BITS-1) to p before the arithmetic shift.
- Undefined: plain truncation toward negative infinity (arithmetic shift only).
- Padding lanes are 0 in both cases.

Test Plan:
- FC1 run, all activations = 1.0 (128), all weights = 1.0:
  - 2592 contiguous start_adder beats, every lane = 128, fully_1 = 1.
  - done 1 cycle after the last beat.
  - The downstream adder yields 576.0 (73728) per neuron.
- FC2 run with all inputs 1.0:
  - 2880 beats, fully_2 = 1.
  - In every 5th beat, lanes 16..31 = 0 and lanes 0..15 = 128.
- Sign and rounding, a = -3 (raw), w = 64:
  - p = -192, shift gives -2 without the macro.
  - With SE_FC_ROUND_EN: -192 + 64 = -128, giving -1.
- Address sequence, FC1 neuron 2:
  - w_addr = 36..53 and act_addr = 0..17.
  - start_adder lags rd_en by exactly 2 cycles.
- start pulsed mid-run with layer_sel = 1: ignored, and the beat count for the running FC1 stays 2592.
- rst deasserted (driven low) at beat 100 of FC1:
  - All outputs go to 0 immediately.
  - A new start then runs a complete, correct FC2 sequence.
